reaction_bot: RTL and testbench

- Automated player for the reaction timer; it is the responder end of the LEDR-stimulus / SW-response interface.
- It watches the game's 10 LEDs. When exactly one LED lights, it waits a programmable number of milliseconds, then raises the matching switch. It holds the switch until the game clears the LEDs.
- Used for hardware self-test and score calibration: it replaces the human on the SW inputs and reports the measured light-to-clear time.

---
 rtl/reaction_bot.sv | 160 ++++++++++++++++
 tb/tb_reaction_bot.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_bot.sv
// reaction_bot: automated responder for the reaction timer game.
// Watches the LED stimulus. When exactly one LED is lit, it waits the programmed
// delay, then raises the matching switch. It reports the measured light-to-clear time.
module reaction_bot #(
   parameter int unsigned CLK_PER_MS = 10000,
   parameter int unsigned TIMEOUT_MS = 1000,
   parameter int unsigned MS_W       = 14
) (
   input  logic            CLK_10MHZ,
   input  logic            rst,
   input  logic            enable,
   input  logic [MS_W-1:0] delay_ms,
   input  logic [9:0]      LEDR,
   output logic [9:0]      SW,
   output logic            resp_valid,
   output logic [MS_W-1:0] measured_ms,
   output logic            err
);

   localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PW-1:0]   PRESC_TC = PW'(CLK_PER_MS - 1);
   localparam logic [MS_W-1:0] MS_MAX   = '1;
   localparam logic [MS_W-1:0] TIMEOUT  = MS_W'(TIMEOUT_MS);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      WAIT    = 3'd2,
      PRESS   = 3'd3,
      RELEASE = 3'd4,
      DRAIN   = 3'd5
   } state_t;

   state_t          state;
   logic [9:0]      led_meta;
   logic [9:0]      led_sync;
   logic [PW-1:0]   presc;
   logic [MS_W-1:0] ms_wait;
   logic [MS_W-1:0] ms_meas;
   logic [MS_W-1:0] delay_lat;
   logic [3:0]      idx_lat;

   logic            ms_tick;
   logic            led_any;
   logic            led_one;
   logic [3:0]      led_idx;

   function automatic logic [MS_W-1:0] sat_inc(input logic [MS_W-1:0] v);
      return (v == MS_MAX) ? v : v + MS_W'(1);
   endfunction

   // Two-flop synchronizer for the asynchronous LED stimulus.
   always_ff @(posedge CLK_10MHZ or posedge rst) begin
      if (rst) begin
         led_meta <= '0;
         led_sync <= '0;
      end else begin
         led_meta <= LEDR;
         led_sync <= led_meta;
      end
   end

   // Decode the synchronized LEDs: any lit, exactly one lit, and which one.
   always_comb begin
      ms_tick = (presc == PRESC_TC);
      led_any = |led_sync;
      led_one = led_any && ((led_sync & (led_sync - 10'd1)) == 10'd0);
      led_idx = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (led_sync[i]) led_idx = 4'(i);
      end
   end

   // Control FSM with prescaler, ms counters and registered outputs.
   always_ff @(posedge CLK_10MHZ or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         presc       <= '0;
         ms_wait     <= '0;
         ms_meas     <= '0;
         delay_lat   <= '0;
         idx_lat     <= '0;
         SW          <= '0;
         resp_valid  <= 1'b0;
         measured_ms <= '0;
         err         <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         presc      <= ms_tick ? '0 : presc + PW'(1);
         if (!enable) begin
            state <= IDLE;
            SW    <= '0;
            err   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  SW    <= '0;
                  state <= ARMED;
               end
               ARMED: begin
                  SW <= '0;
                  if (led_one) begin
                     // Restart the prescaler so the delay is an exact multiple of ms.
                     idx_lat   <= led_idx;
                     delay_lat <= delay_ms;
                     presc     <= '0;
                     ms_wait   <= '0;
                     ms_meas   <= '0;
                     state     <= WAIT;
                  end else if (led_any) begin
                     err <= 1'b1;
                  end
               end
               WAIT: begin
                  if (!led_any) begin
                     state <= ARMED;
                  end else if (ms_wait == delay_lat) begin
                     SW      <= 10'd1 << idx_lat;
                     ms_wait <= '0;
                     if (ms_tick) ms_meas <= sat_inc(ms_meas);
                     state   <= PRESS;
                  end else if (ms_tick) begin
                     ms_wait <= sat_inc(ms_wait);
                     ms_meas <= sat_inc(ms_meas);
                  end
               end
               PRESS: begin
                  if (!led_any) begin
                     SW          <= '0;
                     resp_valid  <= 1'b1;
                     measured_ms <= ms_meas;
                     state       <= RELEASE;
                  end else if (ms_wait >= TIMEOUT) begin
                     // Give up; wait for the game to clear before re-arming.
                     SW    <= '0;
                     err   <= 1'b1;
                     state <= DRAIN;
                  end else if (ms_tick) begin
                     ms_wait <= sat_inc(ms_wait);
                     ms_meas <= sat_inc(ms_meas);
                  end
               end
               RELEASE: begin
                  SW    <= '0;
                  state <= ARMED;
               end
               DRAIN: begin
                  SW <= '0;
                  if (!led_any) state <= ARMED;
               end
               default: begin
                  SW    <= '0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reaction_bot.sv
// Self-checking bench for reaction_bot with a scoreboard of expected measured_ms.
module tb_reaction_bot;

   localparam int unsigned CPM = 10;
   localparam int unsigned TMO = 50;
   localparam int unsigned MW  = 14;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [MW-1:0] delay_ms;
   logic [9:0]    led;
   logic [9:0]    sw;
   logic          resp_valid;
   logic [MW-1:0] measured_ms;
   logic          err;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [MW-1:0] exp_q[$];

   reaction_bot #(.CLK_PER_MS(CPM), .TIMEOUT_MS(TMO), .MS_W(MW)) dut (
      .CLK_10MHZ   (clk),
      .rst         (rst),
      .enable      (enable),
      .delay_ms    (delay_ms),
      .LEDR        (led),
      .SW          (sw),
      .resp_valid  (resp_valid),
      .measured_ms (measured_ms),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Pop the scoreboard on every response pulse and compare.
   always @(negedge clk) begin
      logic [MW-1:0] e;
      if (!rst && resp_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_resp: measured_ms=%0d, required no pulse", measured_ms);
         end else begin
            e = exp_q.pop_front();
            if (measured_ms !== e) begin
               n_bad++;
               $display("FAIL measured_ms: got %0d, required %0d", measured_ms, e);
            end
         end
         n_cmp++;
         if (sw !== 10'd0) begin
            n_bad++;
            $display("FAIL sw_at_resp: got %h, required 000", sw);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full round: SW must rise exactly 3 + d*CPM + 1 edges after LEDR is driven.
   task automatic run_round(input logic [9:0] l, input int d, input int hold);
      int rise;
      bit early;
      bit dropped;
      rise    = 3 + d * int'(CPM) + 1;
      early   = 0;
      dropped = 0;
      exp_q.push_back(MW'((d * int'(CPM) + 3 + hold) / int'(CPM)));
      delay_ms = MW'(d);
      led      = l;
      for (int i = 1; i < rise; i++) begin
         tick(1);
         if (i == 5) delay_ms = MW'(d + 7);
         if (sw !== 10'd0) early = 1;
      end
      tick(1);
      n_cmp++;
      if (early) begin
         n_bad++;
         $display("FAIL early_press: SW asserted before edge %0d, required 000 until then", rise);
      end
      n_cmp++;
      if (sw !== l) begin
         n_bad++;
         $display("FAIL press_edge: got %h at edge %0d, required %h", sw, rise, l);
      end
      for (int i = 0; i < hold; i++) begin
         tick(1);
         if (sw !== l) dropped = 1;
      end
      n_cmp++;
      if (dropped) begin
         n_bad++;
         $display("FAIL hold: SW dropped while LED lit, required %h", l);
      end
      led = 10'd0;
      tick(8);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL resp_missing: %0d responses pending, required 0", exp_q.size());
         exp_q.delete();
      end
      n_cmp++;
      if (sw !== 10'd0) begin
         n_bad++;
         $display("FAIL release: got %h, required 000", sw);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; led = 10'd0; delay_ms = '0;
      tick(2);
      n_cmp++;
      if ({sw, resp_valid, err} !== 12'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: sw=%h rv=%b err=%b, required 000 0 0", sw, resp_valid, err);
      end
      n_cmp++;
      if (measured_ms !== '0) begin
         n_bad++;
         $display("FAIL reset_measured: got %0d, required 0", measured_ms);
      end
      rst = 1'b0; enable = 1'b1;
      tick(2);
   endtask

   task automatic test_reset_mid_press();
      delay_ms = '0;
      led = 10'h008;
      tick(4);
      n_cmp++;
      if (sw !== 10'h008) begin
         n_bad++;
         $display("FAIL pre_reset_press: got %h, required 008", sw);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({sw, resp_valid, err} !== 12'd0) begin
         n_bad++;
         $display("FAIL async_reset: sw=%h rv=%b err=%b, required 000 0 0", sw, resp_valid, err);
      end
      led = 10'd0;
      tick(2);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_normal();
      run_round(10'h010, 5, 3 * int'(CPM));
   endtask

   task automatic test_delay_zero();
      run_round(10'h200, 0, 25);
   endtask

   task automatic test_abort();
      bit pressed;
      pressed  = 0;
      delay_ms = MW'(20);
      led      = 10'h004;
      for (int i = 0; i < 10 * int'(CPM); i++) begin
         tick(1);
         if (sw !== 10'd0) pressed = 1;
      end
      led = 10'd0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (sw !== 10'd0) pressed = 1;
      end
      n_cmp++;
      if (pressed) begin
         n_bad++;
         $display("FAIL abort_press: SW asserted in aborted round, required 000");
      end
      run_round(10'h001, 2, 15);
   endtask

   task automatic test_multi_led();
      bit pressed;
      pressed = 0;
      led = 10'h003;
      tick(4);
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL multi_err: got %b, required 1", err);
      end
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (sw !== 10'd0) pressed = 1;
      end
      n_cmp++;
      if (pressed || err !== 1'b1) begin
         n_bad++;
         $display("FAIL multi_hold: pressed=%b err=%b, required 0 1", pressed, err);
      end
      led = 10'd0; enable = 1'b0;
      tick(1);
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clear: got %b, required 0", err);
      end
      enable = 1'b1;
      tick(2);
      run_round(10'h020, 1, 12);
   endtask

   task automatic test_timeout();
      int  dt;
      bit  pressed;
      dt = -1;
      pressed = 0;
      delay_ms = MW'(1);
      led = 10'h080;
      tick(3 + int'(CPM) + 1);
      n_cmp++;
      if (sw !== 10'h080) begin
         n_bad++;
         $display("FAIL timeout_press: got %h, required 080", sw);
      end
      for (int i = 1; i <= 700; i++) begin
         tick(1);
         if (sw === 10'd0) begin dt = i; break; end
      end
      n_cmp++;
      if (dt < int'(TMO * CPM) - 10 || dt > int'(TMO * CPM) + 10) begin
         n_bad++;
         $display("FAIL timeout_edge: SW dropped after %0d edges, required about %0d", dt, TMO * CPM);
      end
      n_cmp++;
      if (err !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_err: got %b, required 1", err);
      end
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (sw !== 10'd0) pressed = 1;
      end
      n_cmp++;
      if (pressed) begin
         n_bad++;
         $display("FAIL timeout_repress: SW reasserted with LED still lit, required 000");
      end
      led = 10'd0;
      tick(10);
      enable = 1'b0;
      tick(1);
      enable = 1'b1;
      tick(2);
   endtask

   task automatic test_enable_mid_wait();
      bit pressed;
      pressed = 0;
      delay_ms = MW'(10);
      led = 10'h040;
      tick(20);
      enable = 1'b0;
      tick(1);
      n_cmp++;
      if (sw !== 10'd0 || err !== 1'b0) begin
         n_bad++;
         $display("FAIL disable_wait: sw=%h err=%b, required 000 0", sw, err);
      end
      for (int i = 0; i < 150; i++) begin
         tick(1);
         if (sw !== 10'd0) pressed = 1;
      end
      n_cmp++;
      if (pressed) begin
         n_bad++;
         $display("FAIL disable_press: SW asserted while disabled, required 000");
      end
      led = 10'd0;
      tick(3);
      enable = 1'b1;
      tick(2);
      run_round(10'h002, 3, 20);
   endtask

   task automatic test_back_to_back();
      run_round(10'h100, 1, 5);
      run_round(10'h001, 0, 10);
   endtask

   initial begin
      test_reset();
      test_reset_mid_press();
      test_normal();
      test_delay_zero();
      test_abort();
      test_multi_led();
      test_timeout();
      test_enable_mid_wait();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
